shift_counter_param: RTL
========================

Name: shift_counter_param

Overview:
Parametrised shift-register sequence counter. It succeeds the fixed 16-bit Johnson counter.
- Width is generic.
- Two runtime-selectable sequence modes: Johnson (twisted ring) and one-hot ring.
- Runtime shift direction, parallel load, count enable.
- Sequence wrap flag.
- Step rate comes from an integrated tick divider that drives a clock enable. There is no derived clock; everything runs on the single system clock.
- Drives board LEDs directly, or feeds downstream pattern logic.

Parameters:
- WIDTH, 16, counter width in bits; must be >= 2.
- CLK_HZ, 50_000_000, system clock frequency.
- TICK_HZ, 1, step rate.
- DIV (localparam) = CLK_HZ/TICK_HZ; must be >= 1. DIV=1 means step on every enabled cycle.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  count enable; gates both the divider and stepping.
- mode  in  2  00 = Johnson, 01 = ring, 10/11 = hold (reserved).
- dir  in  1  0 = shift toward MSB (left), 1 = shift toward LSB (right).
- load  in  1  parallel load strobe.
- load_val  in  WIDTH  parallel load value.
- q  out  WIDTH  counter state, registered.
- tick  out  1  one-cycle pulse when the divider expires.
- wrap  out  1  one-cycle pulse when a full sequence period completes.

Behaviour:
- Reset (synchronous, active-high; takes effect only at a clk edge): q=0, divider=0, step count=0, tick=0, wrap=0.
- Priority per edge: rst > load > step.
- Divider:
  - Counts 0..DIV-1 only while en=1. While en=0 it holds its value and tick=0.
  - tick=1 for exactly the cycle in which divider==DIV-1 and en=1; the divider then returns to 0.
- Step: occurs on an edge where tick=1, load=0 and mode is not hold. q updates on that same edge, so latency from the tick cycle is 1 edge.
- Johnson:
  - Left: q <= {q[W-2:0], ~q[W-1]}.
  - Right: q <= {~q[0], q[W-1:1]}.
  - Period = 2*WIDTH.
- Ring:
  - Left: q <= {q[W-2:0], q[W-1]}.
  - Right: q <= {q[0], q[W-1:1]}.
  - Period = WIDTH.
  - If q==0 on a step, q <= 1 (bit 0) regardless of dir. This injection step sets step count to 0 and does not raise wrap.
- Hold modes: q, step count and wrap are frozen. The divider and tick keep running.
- Step count: internal, width clog2(2*WIDTH).
  - Increments on each step.
  - When it reaches period-1 and a step occurs, it goes to 0 and wrap=1 for that one cycle. wrap is registered and coincides with the q update.
- Load: q <= load_val, step count <= 0, divider <= 0, wrap <= 0. Any tick coincident with load is discarded; the next tick comes DIV enabled cycles later.
- Mode or dir change:
  - Takes effect on the next step. No state correction is applied.
  - Step count resets to 0 on any mode change (registered compare of mode).
- Non-canonical patterns: in Johnson mode a loaded non-Johnson pattern shifts as-is, with no self-correction. Period and wrap are still counted by step count.
- Simultaneous en=0 and load: the load still executes.

Decomposition:
- Package shift_counter_pkg:
  - MODE_JOHNSON=2'b00, MODE_RING=2'b01, MODE_HOLD=2'b10.
  - DIR_LEFT=0, DIR_RIGHT=1.
  - Function clog2.
- Sub-module tick_gen:
  - Parameter DIV.
  - Ports clk, rst, en, clr, tick.
  - Reusable by other timed lab blocks.
- Top module: holds the shift/step logic and step count.

Test Plan:
All scenarios use WIDTH=4, CLK_HZ=4, TICK_HZ=1 (DIV=4).
1. Johnson left: rst, then en=1, mode=00, dir=0.
   - q steps every 4 clks: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000.
   - wrap pulses exactly on the 8th step (q back to 0000); tick pulses every 4th cycle.
2. Johnson right: from reset, q = 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000, with wrap on the 8th step.
3. Ring left: from reset, the first tick injects 0001 with no wrap. Then 0010, 0100, 1000, 0001; wrap on the 0001 return. Ring right from 0001 gives 1000, 0100, 0010, 0001.
4. Load during tick: load=1, load_val=1010 in the cycle tick=1.
   - q=1010, no step, wrap=0.
   - Next tick exactly 4 cycles later, stepping to 0101 (ring left).
5. Enable gating: en=0 for 10 cycles mid-count.
   - q, divider and tick are frozen or low.
   - On en=1 the remaining divider count resumes and the first tick arrives at the pre-freeze offset.
6. Synchronous reset: assert rst mid-sequence (q=0111) for one cycle between edges without an edge, and q is unchanged. Across an edge: q=0000, tick=0, wrap=0, and the sequence restarts from step 0.

Source files
------------

// File: rtl/shift_counter_pkg.sv
// ---------------------------------------------------------------------------
// shift_counter_pkg
// Shared constants and helpers for the shift-register sequence counter and
// the tick divider.
//   MODE_*  : sequence mode encodings for the 2-bit mode input
//   DIR_*   : shift direction encodings
//   clog2() : ceiling log2 used to size counters from parameters
// ---------------------------------------------------------------------------
package shift_counter_pkg;

    localparam logic [1:0] MODE_JOHNSON = 2'b00;
    localparam logic [1:0] MODE_RING    = 2'b01;
    localparam logic [1:0] MODE_HOLD    = 2'b10;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Number of bits needed to hold the values 0..value-1 (0 for value <= 1).
    function automatic int clog2(input int value);
        int v;
        int r;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_counter_tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
// Clock-enable divider: counts 0..DIV-1 on enabled cycles and flags the
// last count so downstream logic can step once every DIV enabled cycles.
// No derived clock is produced.
// Ports:
//   i_clk  : system clock (rising edge)
//   i_rst  : synchronous active-high reset
//   i_en   : count enable; the count holds and o_tick stays low when 0
//   i_clr  : synchronous restart of the count at 0
//   o_tick : high in the cycle where count == DIV-1 and i_en == 1
// ---------------------------------------------------------------------------
module tick_gen
    import shift_counter_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    // DIV=1 still needs a one-bit counter that simply stays at zero.
    localparam int CW = (clog2(DIV) < 1) ? 1 : clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == LAST);
    // Tick is decoded from the registered count so the step lands on the
    // same edge that wraps the divider.
    assign o_tick = w_last & i_en;

    // Divider count: restart on reset/clear, advance and wrap only when enabled.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            if (w_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + ONE;
            end
        end else begin
            r_cnt <= r_cnt;
        end
    end

endmodule

// File: rtl/shift_counter_param.sv
// ---------------------------------------------------------------------------
// shift_counter_param
// Parametrised shift-register sequence counter (Johnson or one-hot ring)
// stepping at TICK_HZ from an integrated clock-enable divider.
// Ports:
//   i_clk      : system clock (rising edge)
//   i_rst      : synchronous active-high reset
//   i_en       : enable for both divider and stepping
//   i_mode     : 00 Johnson, 01 ring, 10/11 hold
//   i_dir      : 0 shift toward MSB, 1 shift toward LSB
//   i_load     : parallel load strobe (beats any coincident step)
//   i_load_val : parallel load value
//   o_q        : registered counter state
//   o_tick     : one-cycle divider expiry pulse
//   o_wrap     : registered one-cycle pulse when a sequence period completes
// ---------------------------------------------------------------------------
module shift_counter_param
    import shift_counter_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [1:0]       i_mode,
    input  logic             i_dir,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_q,
    output logic             o_tick,
    output logic             o_wrap
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int SCW = clog2(2 * WIDTH);
    localparam logic [SCW-1:0]   J_LAST  = SCW'(2 * WIDTH - 1);
    localparam logic [SCW-1:0]   R_LAST  = SCW'(WIDTH - 1);
    localparam logic [SCW-1:0]   SC_ONE  = SCW'(1);
    localparam logic [WIDTH-1:0] RING_SEED = WIDTH'(1);

    logic [WIDTH-1:0] r_q;
    logic [SCW-1:0]   r_sc;
    logic             r_wrap;
    logic [1:0]       r_mode_prev;

    logic             w_tick;
    logic             w_step;
    logic             w_mode_chg;
    logic [WIDTH-1:0] w_q_next;
    logic [SCW-1:0]   w_sc_next;
    logic             w_wrap_next;

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (i_en),
        .i_clr  (i_load),
        .o_tick (w_tick)
    );

    assign w_step     = w_tick & ~i_load;
    assign w_mode_chg = (i_mode != r_mode_prev);

    // Next-state shift pattern, step count and wrap for a stepping edge.
    always_comb begin
        w_q_next    = r_q;
        w_sc_next   = r_sc;
        w_wrap_next = 1'b0;
        if (w_step) begin
            case (i_mode)
                MODE_JOHNSON: begin
                    if (i_dir == DIR_RIGHT) begin
                        w_q_next = {~r_q[0], r_q[WIDTH-1:1]};
                    end else begin
                        w_q_next = {r_q[WIDTH-2:0], ~r_q[WIDTH-1]};
                    end
                    if (r_sc == J_LAST) begin
                        w_sc_next   = '0;
                        w_wrap_next = 1'b1;
                    end else begin
                        w_sc_next = r_sc + SC_ONE;
                    end
                end
                MODE_RING: begin
                    // An all-zero ring would never move; seed bit 0 and
                    // start the period count from this point.
                    if (r_q == '0) begin
                        w_q_next  = RING_SEED;
                        w_sc_next = '0;
                    end else begin
                        if (i_dir == DIR_RIGHT) begin
                            w_q_next = {r_q[0], r_q[WIDTH-1:1]};
                        end else begin
                            w_q_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                        end
                        if (r_sc == R_LAST) begin
                            w_sc_next   = '0;
                            w_wrap_next = 1'b1;
                        end else begin
                            w_sc_next = r_sc + SC_ONE;
                        end
                    end
                end
                default: begin
                    // Hold modes freeze the pattern and period count.
                    w_q_next    = r_q;
                    w_sc_next   = r_sc;
                    w_wrap_next = 1'b0;
                end
            endcase
        end else begin
            w_q_next    = r_q;
            w_sc_next   = r_sc;
            w_wrap_next = 1'b0;
        end
        // The period count restarts whenever the selected mode differs from
        // the one seen on the previous cycle.
        if (w_mode_chg) begin
            w_sc_next = '0;
        end else begin
            w_sc_next = w_sc_next;
        end
    end

    // State registers: reset beats load, load beats a step.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q         <= '0;
            r_sc        <= '0;
            r_wrap      <= 1'b0;
            r_mode_prev <= MODE_JOHNSON;
        end else begin
            r_mode_prev <= i_mode;
            if (i_load) begin
                r_q    <= i_load_val;
                r_sc   <= '0;
                r_wrap <= 1'b0;
            end else begin
                r_q    <= w_q_next;
                r_sc   <= w_sc_next;
                r_wrap <= w_wrap_next;
            end
        end
    end

    assign o_q    = r_q;
    assign o_tick = w_tick;
    assign o_wrap = r_wrap;

endmodule
